driver_fifo_interface: RTL
==========================

# driver_fifo_interface

Parametrised successor to the single-register audio driver interface: accepts a stream of DATA_SIZE-bit audio samples on an Avalon-ST sink, buffers them in a DEPTH-entry FIFO tagged with a rotating channel index, and exposes them to the HPS/Nios driver through an Avalon-MM slave with data, status and control registers. Adds back-pressure, overflow detection and a level-threshold interrupt. Sits between the audio sample pipeline and the CPU bus.

## Interface
- DATA_SIZE, 28, sample width; DATA_SIZE + CH_W ≤ 31
- DEPTH, 16, FIFO entries; power of two, 2..32768
- NUM_CHANNELS, 2, channels interleaved on the stream; CH_W = max(1, $clog2(NUM_CHANNELS))
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- chipselect  in  1  slave select
- address  in  2  register index
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- source_valid  in  1  sample valid
- source_data  in  DATA_SIZE  sample
- source_ready  out  1  sink ready (= !full)
- read_data  out  32  registered read data
- irq  out  1  level interrupt

## Operation
- Push: source_valid && source_ready at posedge → sample and current channel tag written; channel counter increments, wraps NUM_CHANNELS-1 → 0.
- source_valid && !source_ready → sample dropped, STATUS.overflow set (sticky); channel counter does not advance.
- Address 0 DATA (RO): read pops one entry. read_data = {valid, zero pad, channel[CH_W-1:0], sample[DATA_SIZE-1:0]}; valid = bit 31. Empty pop → read_data = 0, no pointer change.
- Address 1 STATUS (RO): [15:0] level, [16] empty, [17] full, [18] overflow. Reading STATUS clears overflow (unless a new overflow occurs same cycle: set wins).
- Address 2 CONTROL (RW): [15:0] threshold, [16] irq_en, [17] clear (write-only, self-clearing; reads 0). clear flushes FIFO, zeroes channel counter and overflow.
- Address 3: reads 0, writes ignored.
- irq = irq_en && threshold != 0 && level ≥ threshold.
- Writes to addresses 0/1 ignored. Read and write in same cycle: both performed.

## Timing
- Reset values: read_data 0, irq 0, level 0, source_ready 1, threshold 0, irq_en 0, overflow 0, channel counter 0.
- Read latency 1: read_data updated at the edge sampling chipselect && read; holds until next read.
- Push visible in level/irq the cycle after acceptance; pop likewise.
- Simultaneous push and pop: level unchanged; if empty, push accepted and pop returns valid=0 (no bypass).
- Full: source_ready low combinationally from registered full; a pop in that cycle does not allow a same-cycle push.
- clear concurrent with push or pop: clear wins; sample discarded, read_data from the pop is still the pre-clear head.
- Pointers are log2(DEPTH)-bit, wrap naturally; level is log2(DEPTH)+1 bits, zero-extended to 16.
- Reset asserted mid-transfer: all state returns to reset values asynchronously; sample in flight lost.

## Configuration
- DRIVER_FIFO_IRQ_EN defined: threshold/irq_en logic and irq output as above.
- Not defined: irq tied 0, CONTROL[16:0] not stored and reads 0; clear still functional.

## Structure
- Package driver_fifo_pkg: register address localparams (REG_DATA, REG_STATUS, REG_CONTROL), STATUS/CONTROL bit indices, packed struct for CONTROL fields.
- Sub-module sync_fifo (storage array, pointers, level, full/empty) parametrised by width and DEPTH; top holds channel counter, register decode, overflow and irq.

## Test plan
- Reset then push 28'h1234567, read addr 0 → read_data 32'h81234567 (valid, ch 0); STATUS level 0, empty 1.
- Push 28'h1111111, 28'h2222222, 28'h3333333, three DATA reads → channels 0,1,0, values in order, then empty read → 0.
- Push DEPTH+1 samples without reads → source_ready low after 16th, STATUS = full 1, overflow 1, level 16; second STATUS read shows overflow 0.
- Write CONTROL = 0x0001_0004, push 4 → irq high one cycle after 4th push; one DATA read → irq low next cycle.
- Push 3 samples, write CONTROL clear → level 0, next push tagged ch 0.
- Assert rst low mid-burst → source_ready 1, read_data 0, irq 0 immediately; STATUS level 0 after release.

Source files
------------

// File: rtl/driver_fifo_pkg.sv
// Register map, bit positions and CONTROL field layout shared by the audio driver FIFO block.
package driver_fifo_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int ST_EMPTY    = 16;
  localparam int ST_FULL     = 17;
  localparam int ST_OVERFLOW = 18;

  localparam int CTRL_IRQ_EN = 16;
  localparam int CTRL_CLEAR  = 17;

  typedef struct packed {
    logic        clear;
    logic        irq_en;
    logic [15:0] threshold;
  } ctrl_t;

endpackage

// File: rtl/driver_fifo_interface_if.sv
// Avalon-MM slave and Avalon-ST sink signals of the audio driver FIFO, grouped with modports.
interface driver_fifo_interface_if #(
  parameter int DATA_SIZE = 28
) ();
  logic                 chipselect;
  logic [1:0]           address;
  logic                 read;
  logic                 write;
  logic [31:0]          writedata;
  logic                 source_valid;
  logic [DATA_SIZE-1:0] source_data;
  logic                 source_ready;
  logic [31:0]          read_data;
  logic                 irq;

  modport master (
    output chipselect, address, read, write, writedata, source_valid, source_data,
    input  source_ready, read_data, irq
  );

  modport slave (
    input  chipselect, address, read, write, writedata, source_valid, source_data,
    output source_ready, read_data, irq
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; clear flushes pointers and takes priority over push/pop.
module sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/driver_fifo_interface.sv
// Audio sample FIFO with channel tagging, CPU register access, overflow flag and level irq.
// Optional threshold interrupt enabled by defining DRIVER_FIFO_IRQ_EN.
module driver_fifo_interface
  import driver_fifo_pkg::*;
#(
  parameter int DATA_SIZE    = 28,
  parameter int DEPTH        = 16,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  driver_fifo_interface_if.slave bus
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int W    = DATA_SIZE + CH_W;
  localparam int LW   = $clog2(DEPTH) + 1;

  logic [CH_W-1:0] ch_cnt;
  logic [W-1:0]    head;
  logic [LW-1:0]   level;
  logic [15:0]     level16;
  logic            full, empty;
  logic            rd_acc, wr_acc, push, pop, clear, ovf_set, status_rd;
  logic            overflow;
  logic [31:0]     data_word, status_word, ctrl_word, rd_next;
  ctrl_t           wr_ctrl;

  assign rd_acc    = bus.chipselect && bus.read;
  assign wr_acc    = bus.chipselect && bus.write;
  assign wr_ctrl   = ctrl_t'(bus.writedata[CTRL_CLEAR:0]);
  assign clear     = wr_acc && (bus.address == REG_CONTROL) && wr_ctrl.clear;
  assign push      = bus.source_valid && !full;
  assign ovf_set   = bus.source_valid && full;
  assign pop       = rd_acc && (bus.address == REG_DATA) && !empty;
  assign status_rd = rd_acc && (bus.address == REG_STATUS);
  assign level16   = 16'(level);

  // A pop in the full cycle cannot free space for a same-cycle push.
  assign bus.source_ready = !full;

  sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata ({ch_cnt, bus.source_data}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ch_cnt <= '0;
    else if (clear)  ch_cnt <= '0;
    else if (push)   ch_cnt <= (ch_cnt == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_cnt + CH_W'(1);
  end

  // A fresh overflow beats the clear-on-read of STATUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           overflow <= 1'b0;
    else if (clear)     overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (status_rd) overflow <= 1'b0;
  end

`ifdef DRIVER_FIFO_IRQ_EN
  logic [15:0] threshold;
  logic        irq_en;
  logic        unused_wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      threshold <= '0;
      irq_en    <= 1'b0;
    end else if (wr_acc && (bus.address == REG_CONTROL)) begin
      threshold <= wr_ctrl.threshold;
      irq_en    <= wr_ctrl.irq_en;
    end
  end

  assign bus.irq   = irq_en && (threshold != '0) && (level16 >= threshold);
  assign ctrl_word = {15'd0, irq_en, threshold};
  assign unused_wd = ^bus.writedata[31:CTRL_CLEAR+1];
`else
  logic unused_wd;

  assign bus.irq   = 1'b0;
  assign ctrl_word = '0;
  assign unused_wd = ^{bus.writedata[31:CTRL_CLEAR+1], wr_ctrl.irq_en, wr_ctrl.threshold};
`endif

  always_comb begin
    data_word           = '0;
    data_word[W-1:0]    = head;
    data_word[31]       = 1'b1;
    status_word         = '0;
    status_word[15:0]   = level16;
    status_word[ST_EMPTY]    = empty;
    status_word[ST_FULL]     = full;
    status_word[ST_OVERFLOW] = overflow;
    rd_next = '0;
    case (bus.address)
      REG_DATA:    rd_next = empty ? '0 : data_word;
      REG_STATUS:  rd_next = status_word;
      REG_CONTROL: rd_next = ctrl_word;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        bus.read_data <= '0;
    else if (rd_acc) bus.read_data <= rd_next;
  end

endmodule
